// File: rtl/fft_pkg.sv
// ============================================================================
// Module      : fft_pkg
// Description : Shared state encoding and elaboration helpers for the FFT
//               twiddle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        BFLY = 2'd1,
        TWID = 2'd2
    } fft_state_e;

    localparam real C_TWO_PI = 6.283185307179586;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/twiddle_rom.sv
// ============================================================================
// Module      : twiddle_rom
// Description : Combinational twiddle table for k = 0..N_STAGE/2-1, returning
//               (cos, -sin) scaled by 2^FRAC. Define TWIDDLE_QUARTER_ROM_EN
//               to store only a quarter-wave cosine table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module twiddle_rom
    import fft_pkg::*;
#(
    parameter int N_STAGE = 64,
    parameter int W       = 24,
    parameter int FRAC    = 8
) (
    input  logic [clog2(N_STAGE/2)-1:0] k,
    output logic signed [W-1:0]         w_r,
    output logic signed [W-1:0]         w_i
);

    localparam int H  = N_STAGE / 2;
    localparam int KW = clog2(H);

    // Round half away from zero, then truncate to the table width.
    function automatic logic signed [W-1:0] quant(input real x);
        real    r;
        longint m;
        r = (2.0 ** FRAC) * x;
        if (r >= 0.0) begin
            m = longint'($floor(r + 0.5));
        end else begin
            m = -longint'($floor(-r + 0.5));
        end
        return m[W-1:0];
    endfunction

`ifdef TWIDDLE_QUARTER_ROM_EN
    localparam int Q = N_STAGE / 4;
    localparam logic [KW-1:0] C_Q = KW'(Q);

    logic signed [W-1:0] cq [Q+1];

    for (genvar j = 0; j <= Q; j++) begin : g_qtab
        localparam logic signed [W-1:0] C_VAL =
            quant($cos(C_TWO_PI * real'(j) / real'(N_STAGE)));
        assign cq[j] = C_VAL;
    end

    // H-k modulo 2^KW equals -k because H = 2^KW.
    logic [KW-1:0] w_h_minus_k;
    logic [KW-1:0] w_k_minus_q;
    logic [KW-1:0] w_q_minus_k;

    assign w_h_minus_k = -k;
    assign w_k_minus_q = k - C_Q;
    assign w_q_minus_k = C_Q - k;

    always_comb begin
        w_r = '0;
        w_i = '0;
        if (k <= C_Q) begin
            w_r = cq[k];
            w_i = -cq[w_q_minus_k];
        end else begin
            w_r = -cq[w_h_minus_k];
            w_i = -cq[w_k_minus_q];
        end
    end
`else
    logic signed [W-1:0] tab_r [H];
    logic signed [W-1:0] tab_i [H];

    for (genvar j = 0; j < H; j++) begin : g_ftab
        localparam logic signed [W-1:0] C_R =
            quant($cos(C_TWO_PI * real'(j) / real'(N_STAGE)));
        localparam logic signed [W-1:0] C_I =
            -quant($sin(C_TWO_PI * real'(j) / real'(N_STAGE)));
        assign tab_r[j] = C_R;
        assign tab_i[j] = C_I;
    end

    assign w_r = tab_r[k];
    assign w_i = tab_i[k];
`endif

endmodule

`default_nettype wire

// File: rtl/twiddle_seq.sv
// ============================================================================
// Module      : twiddle_seq
// Description : Twiddle and phase sequencer for one radix-2 SDF FFT stage.
//               Build option: TWIDDLE_QUARTER_ROM_EN selects the quarter-wave
//               table inside twiddle_rom.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module twiddle_seq
    import fft_pkg::*;
#(
    parameter int N_STAGE = 64,
    parameter int W       = 24,
    parameter int FRAC    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        inverse,
    output logic signed [W-1:0]         w_r,
    output logic signed [W-1:0]         w_i,
    output logic [1:0]                  state,
    output logic [clog2(N_STAGE/2)-1:0] tw_idx,
    output logic                        out_valid,
    output logic                        frame_done
);

    localparam int H  = N_STAGE / 2;
    localparam int KW = clog2(H);
    localparam logic [KW-1:0]       C_LAST = KW'(H - 1);
    localparam logic signed [W-1:0] C_ONE  = W'(2 ** FRAC);

    fft_state_e          state_q, state_d;
    logic [KW-1:0]       cnt_q, cnt_d;
    logic                inv_q, inv_d;
    logic                inv_eff;
    logic signed [W-1:0] w_r_q, w_r_d;
    logic signed [W-1:0] w_i_q, w_i_d;
    logic [KW-1:0]       tw_idx_q, tw_idx_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic signed [W-1:0] rom_r;
    logic signed [W-1:0] rom_i;

    twiddle_rom #(
        .N_STAGE (N_STAGE),
        .W       (W),
        .FRAC    (FRAC)
    ) u_rom (
        .k   (cnt_q),
        .w_r (rom_r),
        .w_i (rom_i)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inv_d    = inv_q;
        inv_eff  = inv_q;
        w_r_d    = w_r_q;
        w_i_d    = w_i_q;
        tw_idx_d = tw_idx_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        if (in_valid) begin
            valid_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (state_q == TWID) begin
                // The first TWID sample uses the live input and captures it.
                if (cnt_q == '0) begin
                    inv_eff = inverse;
                    inv_d   = inverse;
                end
                tw_idx_d = cnt_q;
                w_r_d    = rom_r;
                w_i_d    = inv_eff ? -rom_i : rom_i;
                done_d   = (cnt_q == C_LAST);
            end else begin
                tw_idx_d = '0;
                w_r_d    = C_ONE;
                w_i_d    = '0;
            end
            if (cnt_q == C_LAST) begin
                case (state_q)
                    FILL:    state_d = BFLY;
                    BFLY:    state_d = TWID;
                    TWID:    state_d = BFLY;
                    default: state_d = FILL;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            cnt_q    <= '0;
            inv_q    <= 1'b0;
            w_r_q    <= C_ONE;
            w_i_q    <= '0;
            tw_idx_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inv_q    <= inv_d;
            w_r_q    <= w_r_d;
            w_i_q    <= w_i_d;
            tw_idx_q <= tw_idx_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    // The reported phase is that of the sample just presented on the outputs.
    logic [1:0] state_out_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_out_q <= 2'(FILL);
        end else if (in_valid) begin
            state_out_q <= 2'(state_q);
        end
    end

    assign w_r        = w_r_q;
    assign w_i        = w_i_q;
    assign state      = state_out_q;
    assign tw_idx     = tw_idx_q;
    assign out_valid  = valid_q;
    assign frame_done = done_q;

endmodule

`default_nettype wire
